// File: rtl/instruction_fetch_request_pkg.sv
// Shared fetch definitions: default outstanding-request budget, FSM encoding and queue payloads.
`timescale 1ns/1ps
package instruction_fetch_request_pkg;

    localparam int FETCH_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE       = 2'd0,
        FETCH_RUN        = 2'd1,
        FETCH_FAULT_HALT = 2'd2
    } fetch_state_t;

    // Sampled at issue, paired with the returning word.
    typedef struct packed {
        logic        paging;
        logic        kernel;
        logic [31:0] pc;
    } fetch_tag_t;

    typedef struct packed {
        logic        pagefault;
        logic [13:0] mmu_flags;
        logic        paging;
        logic        kernel;
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_resp_t;

endpackage

// File: rtl/instruction_fetch_request_fetch_credit_counter.sv
// In-flight request and post-flush discard bookkeeping; zero-latency keep/drop decision per response.
`timescale 1ns/1ps
module fetch_credit_counter #(
    parameter int MAX = 4,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          resp,
    input  logic          flush,
    output logic [CW-1:0] inflight,
    output logic          resp_keep
);

    logic [CW-1:0] discard;
    logic [CW-1:0] inflight_next;
    logic          resp_ok;
    logic          resp_drop;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok       = resp & (inflight != '0);
    assign resp_keep     = resp_ok & (discard == '0);
    assign resp_drop     = resp_ok & (discard != '0);
    assign inflight_next = inflight + CW'(issue) - CW'(resp_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (flush)          discard <= inflight_next;
            else if (resp_drop) discard <= discard - CW'(1);
        end
    end

endmodule

// File: rtl/mist1032isa_sync_fifo.sv
// Registered synchronous FIFO, one-cycle write-to-head latency; DEPTH must be a power of 2.
// clear empties it next edge; push on full is accepted only together with a pop.
`timescale 1ns/1ps
module mist1032isa_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instruction_fetch_request.sv
// Sequential fetch front end: issues I-side reads, pairs words with PC/MMU status, one-cycle response-to-output.
// Issue stops on FETCH_STOP or when in-flight plus held words reach the budget; LOCK holds the FIFO head.
// Build option MIST1032ISA_FETCH_FAULT_HALT_EN: a faulting response halts issue until a flush or branch.
`timescale 1ns/1ps
module instruction_fetch_request
    import instruction_fetch_request_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC        = 32'h0000_0000,
    parameter int          P_MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iFETCH_START,
    input  logic        iFLUSH,
    input  logic        iBRANCH_VALID,
    input  logic [31:0] iBRANCH_ADDR,
    input  logic        iPAGING_ENA,
    input  logic        iKERNEL_ACCESS,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_ACK,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA,
    input  logic        iMEM_PAGEFAULT,
    input  logic [13:0] iMEM_MMU_FLAGS,
    output logic        oNEXT_INST_VALID,
    output logic        oNEXT_PAGEFAULT,
    output logic [13:0] oNEXT_MMU_FLAGS,
    output logic        oNEXT_PAGING_ENA,
    output logic        oNEXT_KERNEL_ACCESS,
    output logic        oNEXT_BRANCH_PREDICT,
    output logic [31:0] oNEXT_BRANCH_PREDICT_ADDR,
    output logic [31:0] oNEXT_INST,
    output logic [31:0] oNEXT_PC,
    input  logic        iNEXT_FETCH_STOP,
    input  logic        iNEXT_LOCK
);

    localparam int          CW    = $clog2(P_MAX_OUTSTANDING + 1);
    localparam logic [CW:0] LIMIT = (CW + 1)'(P_MAX_OUTSTANDING);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic          flush_evt;
    logic          issue;
    logic [CW-1:0] inflight;
    logic          resp_keep;
    logic          resp_push;
    logic [CW:0]   credit_used;
    fetch_tag_t    tag_in;
    fetch_tag_t    tag_head;
    logic          tag_empty;
    logic [CW-1:0] tag_count;
    fetch_resp_t   resp_in;
    fetch_resp_t   resp_head;
    fetch_resp_t   resp_out;
    logic          resp_empty;
    logic [CW-1:0] resp_count;
    logic          out_vld;
    logic          unused_tag_count;

    assign flush_evt   = iFLUSH | iBRANCH_VALID;
    assign credit_used = {1'b0, inflight} + {1'b0, resp_count};
    assign oMEM_REQ    = (state == FETCH_RUN) & !iNEXT_FETCH_STOP & !flush_evt & (credit_used < LIMIT);
    assign oMEM_ADDR   = pc;
    assign issue       = oMEM_REQ & iMEM_ACK;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= FETCH_IDLE;
            pc    <= P_RESET_PC;
        end else begin
            state <= state_next;
            if (iBRANCH_VALID) pc <= iBRANCH_ADDR & 32'hFFFF_FFFC;
            else if (issue)    pc <= pc + 32'd4;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: begin
                if (iFETCH_START) state_next = FETCH_RUN;
            end
            FETCH_RUN: begin
`ifdef MIST1032ISA_FETCH_FAULT_HALT_EN
                if (resp_push && iMEM_PAGEFAULT && !flush_evt) state_next = FETCH_FAULT_HALT;
`else
                state_next = FETCH_RUN;
`endif
            end
            FETCH_FAULT_HALT: begin
                if (flush_evt) state_next = FETCH_RUN;
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    fetch_credit_counter #(.MAX(P_MAX_OUTSTANDING)) u_credit (
        .clk       (iCLOCK),
        .rst       (iRESET),
        .issue     (issue),
        .resp      (iMEM_VALID),
        .flush     (flush_evt),
        .inflight  (inflight),
        .resp_keep (resp_keep)
    );

    assign tag_in = {iPAGING_ENA, iKERNEL_ACCESS, pc};

    mist1032isa_sync_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(P_MAX_OUTSTANDING)) u_tag_q (
        .clk      (iCLOCK),
        .rst      (iRESET),
        .clear    (flush_evt),
        .push     (issue),
        .push_dat (tag_in),
        .pop      (resp_push),
        .head     (tag_head),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // Occupancy of the tag queue mirrors the credit counter's view of kept requests.
    assign unused_tag_count = ^tag_count;

    assign resp_push = resp_keep & !tag_empty;
    assign resp_in   = {iMEM_PAGEFAULT, iMEM_MMU_FLAGS, tag_head.paging, tag_head.kernel, iMEM_DATA, tag_head.pc};
    assign out_vld   = !resp_empty & !iNEXT_LOCK & !flush_evt;

    mist1032isa_sync_fifo #(.WIDTH($bits(fetch_resp_t)), .DEPTH(P_MAX_OUTSTANDING)) u_resp_q (
        .clk      (iCLOCK),
        .rst      (iRESET),
        .clear    (flush_evt),
        .push     (resp_push),
        .push_dat (resp_in),
        .pop      (out_vld),
        .head     (resp_head),
        .empty    (resp_empty),
        .count    (resp_count)
    );

    assign resp_out                  = resp_empty ? '0 : resp_head;
    assign oNEXT_INST_VALID          = out_vld;
    assign oNEXT_PAGEFAULT           = resp_out.pagefault;
    assign oNEXT_MMU_FLAGS           = resp_out.mmu_flags;
    assign oNEXT_PAGING_ENA          = resp_out.paging;
    assign oNEXT_KERNEL_ACCESS       = resp_out.kernel;
    assign oNEXT_INST                = resp_out.inst;
    assign oNEXT_PC                  = resp_out.pc;
    assign oNEXT_BRANCH_PREDICT      = 1'b0;
    assign oNEXT_BRANCH_PREDICT_ADDR = 32'h0;

endmodule

// File: tb/tb_instruction_fetch_request.sv
// Directed bench for instruction_fetch_request with a memory model and an in-order output scoreboard.
`timescale 1ns/1ps
module tb_instruction_fetch_request;

    logic        clk = 1'b0;
    logic        iRESET, iFETCH_START, iFLUSH, iBRANCH_VALID, iPAGING_ENA, iKERNEL_ACCESS;
    logic [31:0] iBRANCH_ADDR, oMEM_ADDR, iMEM_DATA, oNEXT_BRANCH_PREDICT_ADDR, oNEXT_INST, oNEXT_PC;
    logic        oMEM_REQ, iMEM_ACK, iMEM_VALID, iMEM_PAGEFAULT;
    logic [13:0] iMEM_MMU_FLAGS, oNEXT_MMU_FLAGS;
    logic        oNEXT_INST_VALID, oNEXT_PAGEFAULT, oNEXT_PAGING_ENA, oNEXT_KERNEL_ACCESS;
    logic        oNEXT_BRANCH_PREDICT, iNEXT_FETCH_STOP, iNEXT_LOCK;

    always #5 clk = ~clk;

    instruction_fetch_request dut (
        .iCLOCK(clk), .iRESET(iRESET), .iFETCH_START(iFETCH_START), .iFLUSH(iFLUSH),
        .iBRANCH_VALID(iBRANCH_VALID), .iBRANCH_ADDR(iBRANCH_ADDR), .iPAGING_ENA(iPAGING_ENA),
        .iKERNEL_ACCESS(iKERNEL_ACCESS), .oMEM_REQ(oMEM_REQ), .oMEM_ADDR(oMEM_ADDR), .iMEM_ACK(iMEM_ACK),
        .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA), .iMEM_PAGEFAULT(iMEM_PAGEFAULT),
        .iMEM_MMU_FLAGS(iMEM_MMU_FLAGS), .oNEXT_INST_VALID(oNEXT_INST_VALID), .oNEXT_PAGEFAULT(oNEXT_PAGEFAULT),
        .oNEXT_MMU_FLAGS(oNEXT_MMU_FLAGS), .oNEXT_PAGING_ENA(oNEXT_PAGING_ENA),
        .oNEXT_KERNEL_ACCESS(oNEXT_KERNEL_ACCESS), .oNEXT_BRANCH_PREDICT(oNEXT_BRANCH_PREDICT),
        .oNEXT_BRANCH_PREDICT_ADDR(oNEXT_BRANCH_PREDICT_ADDR), .oNEXT_INST(oNEXT_INST), .oNEXT_PC(oNEXT_PC),
        .iNEXT_FETCH_STOP(iNEXT_FETCH_STOP), .iNEXT_LOCK(iNEXT_LOCK)
    );

    typedef struct { logic [31:0] addr; int due; logic paging; logic kernel; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] status; } exp_t;

    localparam int RESP_DLY = 2;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          checks = 0, failures = 0, cyc = 0, n_acc = 0, n_resp = 0, stale_left = 0;
    int          first_resp_cyc = -1, first_valid_cyc = -1, a0;
    logic        start_p = 0, flush_p = 0, branch_p = 0, lock = 0, stop = 0, ack_en = 0, resp_en = 0;
    logic [31:0] branch_a = 0, fault_addr = 32'h1, exp_addr = 0, last_acc_addr = 0, last_out_pc = 0, held_pc;
    logic        last_valid = 0, last_req = 0, saw_fault = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] status_of(input logic pf, input logic [13:0] fl, input logic pg, input logic kn);
        return {15'd0, pf, fl, pg, kn};
    endfunction

    // One clock: drive at the falling edge, observe 1ns later, commit at the rising edge.
    task automatic step();
        mreq_t m;
        exp_t  e;
        logic  fl;
        fl = flush_p | branch_p;
        iFETCH_START = start_p; iFLUSH = flush_p; iBRANCH_VALID = branch_p; iBRANCH_ADDR = branch_a;
        iNEXT_LOCK = lock; iNEXT_FETCH_STOP = stop; iMEM_ACK = ack_en;
        iPAGING_ENA = cyc[0]; iKERNEL_ACCESS = cyc[1];
        iMEM_VALID = 0; iMEM_DATA = 0; iMEM_PAGEFAULT = 0; iMEM_MMU_FLAGS = 0;
        if (resp_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            iMEM_VALID = 1; iMEM_DATA = ~m.addr; iMEM_PAGEFAULT = (m.addr == fault_addr);
            iMEM_MMU_FLAGS = m.addr[15:2];
            if (first_resp_cyc < 0) first_resp_cyc = cyc;
            n_resp++;
            if (stale_left > 0) stale_left--;
            else if (!fl) begin
                e.pc = m.addr; e.inst = ~m.addr;
                e.status = status_of(m.addr == fault_addr, m.addr[15:2], m.paging, m.kernel);
                exp_q.push_back(e);
            end
        end
        #1;
        last_valid = oNEXT_INST_VALID;
        last_req   = oMEM_REQ;
        if (oNEXT_INST_VALID) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_pc", oNEXT_PC, e.pc);
                chk("out_inst", oNEXT_INST, e.inst);
                chk("out_status", status_of(oNEXT_PAGEFAULT, oNEXT_MMU_FLAGS, oNEXT_PAGING_ENA, oNEXT_KERNEL_ACCESS), e.status);
            end
            last_out_pc = oNEXT_PC;
            if (oNEXT_PC == fault_addr) saw_fault = 1;
        end
        if (fl) begin
            chk("flush_noreq", 32'(oMEM_REQ), 32'd0);
            chk("flush_novalid", 32'(oNEXT_INST_VALID), 32'd0);
            exp_q.delete();
            stale_left = mem_q.size();
            if (branch_p) exp_addr = branch_a & 32'hFFFF_FFFC;
        end
        if (oMEM_REQ && iMEM_ACK) begin
            chk("mem_addr", oMEM_ADDR, exp_addr);
            m.addr = oMEM_ADDR; m.due = cyc + RESP_DLY; m.paging = iPAGING_ENA; m.kernel = iKERNEL_ACCESS;
            mem_q.push_back(m);
            exp_addr = exp_addr + 32'd4;
            last_acc_addr = oMEM_ADDR;
            n_acc++;
        end
        start_p = 0; flush_p = 0; branch_p = 0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        ack_en = 0; resp_en = 1; lock = 0; stop = 0;
        for (int i = 0; i < 40 && (mem_q.size() > 0 || exp_q.size() > 0); i++) step();
        step();
        chk("drain_empty", 32'(mem_q.size() + exp_q.size()), 32'd0);
        chk("drain_idle", 32'(last_valid), 32'd0);
    endtask

    initial begin
        iRESET = 1; iFETCH_START = 0; iFLUSH = 0; iBRANCH_VALID = 0; iBRANCH_ADDR = 0; iPAGING_ENA = 0;
        iKERNEL_ACCESS = 0; iMEM_ACK = 0; iMEM_VALID = 0; iMEM_DATA = 0; iMEM_PAGEFAULT = 0;
        iMEM_MMU_FLAGS = 0; iNEXT_FETCH_STOP = 0; iNEXT_LOCK = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(oMEM_REQ), 32'd0);
        chk("rst_addr", oMEM_ADDR, 32'h0);
        chk("rst_valid", 32'(oNEXT_INST_VALID), 32'd0);
        chk("rst_pc", oNEXT_PC, 32'h0);
        chk("rst_pred", {oNEXT_BRANCH_PREDICT_ADDR[30:0], oNEXT_BRANCH_PREDICT}, 32'h0);
        iRESET = 0;
        step();
        chk("idle_noreq", 32'(last_req), 32'd0);

        // Sequential streaming, ACK every cycle, responses two cycles later.
        start_p = 1; ack_en = 1; resp_en = 1;
        step();
        for (int i = 0; i < 10 && first_valid_cyc < 0; i++) step();
        chk("first_latency", 32'(first_valid_cyc - first_resp_cyc), 32'd1);
        repeat (10) step();

        // Credit limit: four accepts without responses, then re-issue after the first pop.
        drain();
        ack_en = 1; resp_en = 0; a0 = n_acc;
        repeat (6) step();
        chk("credit_acc", 32'(n_acc - a0), 32'd4);
        chk("credit_req_low", 32'(last_req), 32'd0);
        ack_en = 0; resp_en = 1;
        for (int i = 0; i < 10 && !last_valid; i++) step();
        chk("credit_pop", 32'(last_valid), 32'd1);
        chk("credit_req_at_pop", 32'(last_req), 32'd0);
        step();
        chk("credit_req_back", 32'(last_req), 32'd1);

        // Branch with three requests in flight.
        drain();
        resp_en = 0; ack_en = 1; a0 = n_acc;
        repeat (3) step();
        chk("br_inflight", 32'(n_acc - a0), 32'd3);
        ack_en = 0; branch_p = 1; branch_a = 32'h0000_1003;
        step();
        ack_en = 1; resp_en = 1; a0 = n_acc;
        step();
        chk("br_req", 32'(n_acc - a0), 32'd1);
        chk("br_addr", last_acc_addr, 32'h0000_1000);
        for (int i = 0; i < 20 && !last_valid; i++) step();
        chk("br_first_pc", last_out_pc, 32'h0000_1000);
        repeat (8) step();

        // Downstream lock holds four words, then they drain back to back.
        drain();
        lock = 1; ack_en = 1; resp_en = 1; a0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("lock_novalid", 32'(last_valid), 32'd0);
        end
        chk("lock_acc", 32'(n_acc - a0), 32'd4);
        chk("lock_noreq", 32'(last_req), 32'd0);
        lock = 0; ack_en = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lock_drain", 32'(last_valid), 32'd1);
        end
        step();
        chk("lock_drained", 32'(last_valid), 32'd0);

        // Fetch stop, then PC wrap at the top of the address space.
        drain();
        stop = 1; ack_en = 1;
        repeat (2) step();
        chk("stop_noreq", 32'(last_req), 32'd0);
        stop = 0; ack_en = 0; branch_p = 1; branch_a = 32'hFFFF_FFFC;
        step();
        ack_en = 1; resp_en = 1;
        step();
        chk("wrap_top", last_acc_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_zero", last_acc_addr, 32'h0000_0000);
        repeat (8) step();

        // Translation fault on a sequential word.
        drain();
        fault_addr = exp_addr + 32'd8; saw_fault = 0; ack_en = 1; resp_en = 1;
        for (int i = 0; i < 20 && !saw_fault; i++) step();
        chk("fault_delivered", 32'(saw_fault), 32'd1);
`ifdef MIST1032ISA_FETCH_FAULT_HALT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_noreq", 32'(last_req), 32'd0);
        end
        held_pc = exp_addr;
        flush_p = 1;
        step();
        step();
        chk("halt_resume_req", 32'(last_req), 32'd1);
        chk("halt_resume_addr", last_acc_addr, held_pc);
`else
        held_pc = exp_addr;
        step();
        chk("nohalt_req", 32'(last_req), 32'd1);
        chk("nohalt_addr", last_acc_addr, held_pc);
`endif
        fault_addr = 32'h1;
        repeat (6) step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
